// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle ADD/SUB/AND/OR and an iterative shift-add
// MUL taking WIDTH cycles, exposed through a valid/ready handshake.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // The edge that sees this count completes the WIDTH-th iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic {
    S_IDLE,
    S_MUL_BUSY
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_valid;

  state_e           w_state_nx;
  logic [WIDTH-1:0] w_m_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH-1:0] w_p_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [WIDTH-1:0] w_data_nx;
  logic             w_zero_nx;
  logic             w_valid_nx;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_p_acc;

  always_comb begin
    unique case (ALUCtrl_i)
      OP_SUB:  w_alu_res = data1_i - data2_i;
      OP_AND:  w_alu_res = data1_i & data2_i;
      OP_OR:   w_alu_res = data1_i | data2_i;
      default: w_alu_res = data1_i + data2_i;
    endcase
  end

  assign w_p_acc = r_q[0] ? (r_p + r_m) : r_p;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
    w_state_nx = r_state;
    w_m_nx     = r_m;
    w_q_nx     = r_q;
    w_p_nx     = r_p;
    w_cnt_nx   = r_cnt;
    w_data_nx  = r_data;
    w_zero_nx  = r_zero;
    w_valid_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            w_m_nx     = data1_i;
            w_q_nx     = data2_i;
            w_p_nx     = '0;
            w_cnt_nx   = '0;
            w_state_nx = S_MUL_BUSY;
          end else begin
            w_data_nx  = w_alu_res;
            w_zero_nx  = (w_alu_res == '0);
            w_valid_nx = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        w_p_nx   = w_p_acc;
        w_m_nx   = r_m << 1;
        w_q_nx   = r_q >> 1;
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt == LAST_ITER) begin
          w_data_nx  = w_p_acc;
          w_zero_nx  = (w_p_acc == '0);
          w_valid_nx = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_q     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_zero  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_m     <= w_m_nx;
      r_q     <= w_q_nx;
      r_p     <= w_p_nx;
      r_cnt   <= w_cnt_nx;
      r_data  <= w_data_nx;
      r_zero  <= w_zero_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign zero_o  = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a scoreboard queue holds expected results,
// and a negedge monitor pops and checks them whenever valid_o pulses.
module tb_multicycle_alu;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] mon_exp;

  always #5 clk_i = ~clk_i;

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      OP_MUL:  return prod[WIDTH-1:0];
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a + b;
    endcase
  endfunction

  // Drive a request for the coming edge and record what it must produce.
  task automatic push_req(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    sb.push_back(exp);
  endtask

  // One request from idle, then wait (bounded) for the scoreboard to drain.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    @(negedge clk_i);
    check_bit({tag, "_ready"}, ready_o, 1'b1);
    push_req(op, a, b, exp);
    @(negedge clk_i);
    valid_i = 1'b0;
    for (int i = 0; i < WIDTH + 4 && sb.size() != 0; i++) @(negedge clk_i);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_bit("unexpected_valid", valid_o, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        check("result_data", data_o, mon_exp);
        check_bit("result_zero", zero_o, mon_exp == '0);
      end
    end
  end

  initial begin
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    rst_i     = 1'b1;
    valid_i   = 1'b0;
    ALUCtrl_i = OP_ADD;
    data1_i   = '0;
    data2_i   = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    @(negedge clk_i);
    check_bit("reset_ready", ready_o, 1'b1);
    check_bit("reset_valid", valid_o, 1'b0);
    check("reset_data", data_o, 32'd0);
    check_bit("reset_zero", zero_o, 1'b1);

    // Back-to-back single-cycle ops in cycles 0..3.
    @(negedge clk_i);
    push_req(OP_ADD, 32'd5, 32'd7, 32'd12);
    @(negedge clk_i);
    check_bit("b2b_ready", ready_o, 1'b1);
    check_bit("b2b_valid1", valid_o, 1'b1);
    push_req(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
    @(negedge clk_i);
    check_bit("b2b_valid2", valid_o, 1'b1);
    push_req(OP_AND, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h00F0_000F);
    @(negedge clk_i);
    check_bit("b2b_valid3", valid_o, 1'b1);
    push_req(OP_OR, 32'h0000_1234, 32'h8000_0000, 32'h8000_1234);
    @(negedge clk_i);
    valid_i = 1'b0;
    check_bit("b2b_valid4", valid_o, 1'b1);
    @(negedge clk_i);
    check_bit("b2b_valid_drop", valid_o, 1'b0);

    run_op("sub_zero", OP_SUB, 32'd9, 32'd9, 32'd0);

    // MUL latency: busy in cycles 1..32, result in cycle 33.
    @(negedge clk_i);
    push_req(OP_MUL, 32'd1234, 32'd5678, 32'd7006652);
    for (int c = 1; c <= WIDTH; c++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      check_bit("mul_busy_ready", ready_o, 1'b0);
      check_bit("mul_busy_valid", valid_o, 1'b0);
    end
    @(negedge clk_i);
    check_bit("mul_done_valid", valid_o, 1'b1);
    check_bit("mul_done_ready", ready_o, 1'b1);
    @(negedge clk_i);
    check_bit("mul_pulse_end", valid_o, 1'b0);

    run_op("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_op("mul_wrap", OP_MUL, 32'h8000_0000, 32'd2, 32'd0);

    // Held ADD request with toggling operands during a MUL is ignored until ready.
    @(negedge clk_i);
    push_req(OP_MUL, 32'd1234, 32'd5678, 32'd7006652);
    for (int c = 1; c <= WIDTH; c++) begin
      @(negedge clk_i);
      valid_i   = 1'b1;
      ALUCtrl_i = OP_ADD;
      data1_i   = $urandom();
      data2_i   = $urandom();
      check_bit("hold_busy_ready", ready_o, 1'b0);
    end
    @(negedge clk_i);
    check_bit("hold_mul_valid", valid_o, 1'b1);
    check_bit("hold_ready", ready_o, 1'b1);
    push_req(OP_ADD, 32'd100, 32'd23, 32'd123);
    @(negedge clk_i);
    valid_i = 1'b0;
    check_bit("hold_add_valid", valid_o, 1'b1);
    @(negedge clk_i);
    check("hold_drained", 32'(sb.size()), 32'd0);

    // Reset in cycle 10 of a MUL aborts it without a result.
    @(negedge clk_i);
    push_req(OP_MUL, 32'd1234, 32'd5678, 32'd7006652);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    check_bit("abort_ready", ready_o, 1'b1);
    check("abort_data", data_o, 32'd0);
    check_bit("abort_zero", zero_o, 1'b1);
    for (int c = 12; c <= WIDTH + 3; c++) begin
      @(negedge clk_i);
      check_bit("abort_no_valid", valid_o, 1'b0);
    end

    // Undefined opcode behaves as ADD with single-cycle latency.
    @(negedge clk_i);
    push_req(3'b111, 32'd2, 32'd3, 32'd5);
    @(negedge clk_i);
    valid_i = 1'b0;
    check_bit("op111_valid", valid_o, 1'b1);
    check("op111_data", data_o, 32'd5);
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom();
      r_b  = $urandom();
      run_op("random", r_op, r_a, r_b, model(r_op, r_a, r_b));
    end

    repeat (2) @(negedge clk_i);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execution-stage ALU that consumes the 3-bit `ALUCtrl` code produced by ALU control and performs ADD/SUB/AND/OR in one cycle and MUL iteratively in WIDTH cycles. A valid/ready handshake exposes the multi-cycle latency, so the hazard/stall logic can freeze the upstream pipeline while a multiply is in flight. Results are registered and presented with a one-cycle `valid_o` pulse.

## Interface
- `WIDTH`, 32, operand and result width in bits.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  operation request; qualified by `ready_o`.
- `ALUCtrl_i`  in  3  operation code: 000 ADD, 001 MUL, 010 SUB, 011 AND, 100 OR; 101–111 are treated as ADD.
- `data1_i`  in  WIDTH  operand A.
- `data2_i`  in  WIDTH  operand B.
- `ready_o`  out  1  block can accept a request this cycle.
- `valid_o`  out  1  one-cycle pulse; `data_o`/`zero_o` hold a new result.
- `data_o`  out  WIDTH  registered result; held until the next result.
- `zero_o`  out  1  registered (`data_o == 0`), updated together with `data_o`.

## Operation
- States: IDLE, MUL_BUSY.
- IDLE:
  - `ready_o` = 1.
  - Accept occurs when `valid_i` && `ready_o` is sampled at an edge.
- Accepted non-MUL op:
  - ADD: A+B. SUB: A−B (two's complement). AND: A&B. OR: A|B.
  - All results wrap modulo 2^WIDTH; no overflow flag.
  - Result is written to `data_o`/`zero_o` at the accepting edge and `valid_o` is set. State remains IDLE.
- Accepted MUL:
  - Load multiplicand M=A, multiplier Q=B, accumulator P=0, counter=0. Go to MUL_BUSY.
  - `ready_o` = 0 in MUL_BUSY.
- MUL_BUSY iteration, one per edge:
  - If Q[0], P ← P+M (mod 2^WIDTH).
  - Then M ← M<<1, Q ← Q>>1, counter++.
  - On the edge where counter reaches WIDTH: `data_o` ← final P, `zero_o` ← (P==0), `valid_o` ← 1, state ← IDLE.
  - Result is the low WIDTH bits of the product, identical for signed and unsigned operands.
- `valid_i` is ignored while in MUL_BUSY. Upstream holds its request until `ready_o`. No request is queued or dropped silently.
- `data1_i`, `data2_i` and `ALUCtrl_i` are sampled only at the accepting edge. Later changes do not affect an in-flight MUL.
- `valid_o` is 0 in every cycle not immediately following a completion edge.

## Timing
- Reset values:
  - State IDLE, `ready_o` = 1, `valid_o` = 0.
  - `data_o` = 0, `zero_o` = 1.
  - Internal P, M, Q and counter = 0.
- Reset takes priority over everything, including an in-flight MUL, which is aborted with no `valid_o` pulse. The first accept is possible in the cycle after `rst_i` deasserts.
- Non-MUL latency:
  - Accept in cycle 0 gives `valid_o` = 1 in cycle 1.
  - Back-to-back accepts every cycle are supported, giving one result per cycle.
- MUL latency:
  - Accept in cycle 0, busy in cycles 1..WIDTH (`ready_o` = 0).
  - `valid_o` = 1 and `ready_o` = 1 in cycle WIDTH+1. For WIDTH=32, that is 33 cycles from accept to result.
- A new request can be accepted in the same cycle that `valid_o` is high. Its result follows the normal latency.
- Fixed latency: no early termination when Q becomes zero.

## Test plan
- Reset, then idle with `valid_i` = 0 → `ready_o` = 1, `valid_o` = 0, `data_o` = 0, `zero_o` = 1.
- Back-to-back requests in cycles 0–3: ADD 5+7, SUB 3−5, AND 0xF0F0_00FF&0x0FF0_FF0F, OR 0x0000_1234|0x8000_0000 → `valid_o` in cycles 1–4 with `data_o` = 12, 0xFFFF_FFFE, 0x00F0_000F, 0x8000_1234.
  - Additionally, SUB 9−9 → `data_o` = 0 and `zero_o` = 1.
- MUL 1234×5678 accepted in cycle 0 → `ready_o` = 0 in cycles 1–32; `valid_o` and `data_o` = 7006652 in cycle 33.
  - MUL 0xFFFF_FFFF×0xFFFF_FFFF → `data_o` = 1.
  - MUL 0x8000_0000×2 → `data_o` = 0, `zero_o` = 1.
- During MUL_BUSY, hold `valid_i` = 1 with an ADD and toggle the operands → only the MUL result appears in cycle 33. The ADD is accepted in cycle 33 and its result appears in cycle 34.
- Assert `rst_i` in cycle 10 of a MUL → next cycle is IDLE, `ready_o` = 1, `data_o` = 0, and no `valid_o` pulse appears in cycle 33.
- `ALUCtrl_i` = 3'b111 with 2,3 → `data_o` = 5 (ADD) in cycle 1.
